// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, ACK.
// Optional build macro PS2_TX_RESEND_EN adds one automatic retransmission after a failed frame.
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 15000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic       kclk_oe_o,
  output logic       kdata_oe_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       timeout_o
);

  localparam int unsigned CyclesPerUs = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned InhibitCyc  = CyclesPerUs * INHIBIT_US;
  localparam int unsigned TimeoutCyc  = CyclesPerUs * TIMEOUT_US;
  localparam int unsigned CntMax      = (InhibitCyc > TimeoutCyc) ? InhibitCyc : TimeoutCyc;
  localparam int unsigned CntW        = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] InhibitLast = CntW'(InhibitCyc - 1);
  localparam logic [CntW-1:0] TimeoutLim  = CntW'(TimeoutCyc);
  localparam logic [CntW-1:0] CntSat      = CntW'(CntMax);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StSend,
    StAck,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            parity_q, parity_d;
  logic            ack_bad_q, ack_bad_d;
  logic            kclk_oe_q, kclk_oe_d;
  logic            kdata_oe_q, kdata_oe_d;
  logic            done_q, done_d;
  logic            ack_err_q, ack_err_d;
  logic            timeout_q, timeout_d;
  logic            tx_ready_q, tx_ready_d;
`ifdef PS2_TX_RESEND_EN
  logic            retry_q, retry_d;
`endif

  logic kclk_s1_q, kclk_s2_q, kclk_prev_q;
  logic kdata_s1_q, kdata_s2_q;
  logic kclk_fall;
  logic [CntW-1:0] cnt_inc;
  logic frame_end;
  logic stall;

  // Pads idle high, so the synchronisers reset high to avoid a phantom fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kclk_s1_q   <= 1'b1;
      kclk_s2_q   <= 1'b1;
      kclk_prev_q <= 1'b1;
      kdata_s1_q  <= 1'b1;
      kdata_s2_q  <= 1'b1;
    end else begin
      kclk_s1_q   <= kclk_i;
      kclk_s2_q   <= kclk_s1_q;
      kclk_prev_q <= kclk_s2_q;
      kdata_s1_q  <= kdata_i;
      kdata_s2_q  <= kdata_s1_q;
    end
  end

  assign kclk_fall = kclk_prev_q & ~kclk_s2_q;
  assign cnt_inc   = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    parity_d   = parity_q;
    ack_bad_d  = ack_bad_q;
    kclk_oe_d  = kclk_oe_q;
    kdata_oe_d = kdata_oe_q;
    done_d     = 1'b0;
    ack_err_d  = 1'b0;
    timeout_d  = 1'b0;
    frame_end  = 1'b0;
    stall      = 1'b0;
`ifdef PS2_TX_RESEND_EN
    retry_d    = retry_q;
`endif

    unique case (state_q)
      StIdle: begin
        kclk_oe_d  = 1'b0;
        kdata_oe_d = 1'b0;
        if (tx_valid_i && tx_ready_q) begin
          data_d    = tx_data_i;
          parity_d  = ~^tx_data_i;
          cnt_d     = '0;
          kclk_oe_d = 1'b1;
          state_d   = StInhibit;
`ifdef PS2_TX_RESEND_EN
          retry_d   = 1'b0;
`endif
        end
      end
      StInhibit: begin
        kclk_oe_d  = 1'b1;
        kdata_oe_d = 1'b0;
        if (cnt_q >= InhibitLast) begin
          kdata_oe_d = 1'b1;
          state_d    = StRts;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRts: begin
        kclk_oe_d  = 1'b0;
        kdata_oe_d = 1'b1;
        cnt_d      = '0;
        bit_cnt_d  = '0;
        ack_bad_d  = 1'b0;
        // Shifted out LSB first on falls 1..10: data, parity, stop.
        shift_d    = {1'b1, parity_q, data_q};
        state_d    = StSend;
      end
      StSend: begin
        if (kclk_fall) begin
          cnt_d      = '0;
          kdata_oe_d = ~shift_q[0];
          shift_d    = {1'b1, shift_q[9:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = StAck;
          end
        end else if (cnt_q >= TimeoutLim) begin
          stall = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StAck: begin
        if (kclk_fall) begin
          cnt_d     = '0;
          ack_bad_d = kdata_s2_q;
          state_d   = StWaitIdle;
        end else if (cnt_q >= TimeoutLim) begin
          stall = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitIdle: begin
        if (kclk_s2_q && kdata_s2_q) begin
          frame_end = 1'b1;
        end else if (kclk_fall) begin
          cnt_d = '0;
        end else if (cnt_q >= TimeoutLim) begin
          stall = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_end || stall) begin
`ifdef PS2_TX_RESEND_EN
      if (!retry_q && (stall || ack_bad_q)) begin
        retry_d    = 1'b1;
        cnt_d      = '0;
        kclk_oe_d  = 1'b1;
        kdata_oe_d = 1'b0;
        state_d    = StInhibit;
      end else
`endif
      begin
        kclk_oe_d  = 1'b0;
        kdata_oe_d = 1'b0;
        done_d     = frame_end;
        ack_err_d  = frame_end & ack_bad_q;
        timeout_d  = stall;
        state_d    = StIdle;
      end
    end

    tx_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      ack_bad_q  <= 1'b0;
      kclk_oe_q  <= 1'b0;
      kdata_oe_q <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      tx_ready_q <= 1'b1;
`ifdef PS2_TX_RESEND_EN
      retry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      ack_bad_q  <= ack_bad_d;
      kclk_oe_q  <= kclk_oe_d;
      kdata_oe_q <= kdata_oe_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      timeout_q  <= timeout_d;
      tx_ready_q <= tx_ready_d;
`ifdef PS2_TX_RESEND_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign tx_ready_o = tx_ready_q;
  assign kclk_oe_o  = kclk_oe_q;
  assign kdata_oe_o = kdata_oe_q;
  assign done_o     = done_q;
  assign ack_err_o  = ack_err_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model, a ~12 kHz PS/2 device model and a pulse scoreboard.
module tb_ps2_host_tx;

  typedef struct packed {
    logic ack_err;
    logic timeout;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       kclk_oe, kdata_oe;
  logic       done, ack_err, timeout;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       kclk, kdata;

  int   total = 0;
  int   bad = 0;
  int   ev_cnt = 0;
  int   dev_nclk = 0;
  ev_t  exp_q[$];

  assign kclk  = dev_clk & ~kclk_oe;
  assign kdata = dev_data & ~kdata_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ(1_000_000),
    .INHIBIT_US (100),
    .TIMEOUT_US (2000)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tx_data_i (tx_data),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .kclk_i    (kclk),
    .kdata_i   (kdata),
    .kclk_oe_o (kclk_oe),
    .kdata_oe_o(kdata_oe),
    .done_o    (done),
    .ack_err_o (ack_err),
    .timeout_o (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the expected outcome for every completion pulse the DUT emits.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (done || timeout || ack_err)) begin
      check("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pulse_done", done, !e.timeout);
        check("pulse_ack_err", ack_err, e.ack_err);
        check("pulse_timeout", timeout, e.timeout);
      end
      ev_cnt++;
    end
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: wait for RTS, clock 10 bits in on rising edges, then the ACK clock.
  task automatic dev_frame(input bit give_ack, output logic [10:0] smp);
    int n = 0;
    smp = '0;
    dev_nclk = 0;
    while (!(kclk === 1'b1 && kdata === 1'b0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("dev_rts_seen", n < 5000, 1);
    smp[0] = kdata;
    for (int i = 1; i <= 10; i++) begin
      repeat (40) @(negedge clk);
      dev_clk = 1'b0;
      dev_nclk++;
      repeat (40) @(negedge clk);
      dev_clk = 1'b1;
      smp[i] = kdata;
    end
    repeat (20) @(negedge clk);
    if (give_ack) dev_data = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk = 1'b0;
    dev_nclk++;
    repeat (40) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic wait_event(input string tag, input int target);
    int n = 0;
    while (ev_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, ev_cnt >= target, 1);
  endtask

  task automatic wait_rts(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(kclk_oe && kdata_oe) && n < 5000);
    check(tag, n < 5000, 1);
  endtask

  initial begin
    logic [10:0] smp;
    int          cnt;

    repeat (3) @(negedge clk);
    check("reset_ready", tx_ready, 1);
    check("reset_oe", {kclk_oe, kdata_oe}, 0);
    check("reset_pulses", {done, ack_err, timeout}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 0xED with ACK, inhibit length and device-sampled bits
    exp_q.push_back('{ack_err: 1'b0, timeout: 1'b0});
    send(8'hED);
    check("t1_busy", tx_ready, 0);
    cnt = 0;
    while (kclk_oe && !kdata_oe && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    check("t1_inhibit_len", cnt, 100);
    check("t1_rts", {kclk_oe, kdata_oe}, 2'b11);
    dev_frame(1'b1, smp);
    check("t1_bits", smp, frame_bits(8'hED));
    wait_event("t1_done_seen", 1);

    // 2: 0x55 with NACK
    exp_q.push_back('{ack_err: 1'b1, timeout: 1'b0});
    send(8'h55);
    dev_frame(1'b0, smp);
    check("t2_bits", smp, frame_bits(8'h55));
`ifdef PS2_TX_RESEND_EN
    dev_frame(1'b0, smp);
    check("t2_retry_bits", smp, frame_bits(8'h55));
`endif
    wait_event("t2_done_seen", 2);
    @(negedge clk);
    check("t2_ready_after", tx_ready, 1);

    // 3: 0xFF, device silent
    exp_q.push_back('{ack_err: 1'b0, timeout: 1'b1});
    send(8'hFF);
`ifdef PS2_TX_RESEND_EN
    wait_rts("t3_rts_first");
`endif
    wait_rts("t3_rts");
    cnt = 0;
    while (!timeout && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check("t3_latency_ok", (cnt >= 1997) && (cnt <= 2003), 1);
    check("t3_released", {kclk_oe, kdata_oe}, 0);
    check("t3_no_done", done, 0);
    wait_event("t3_timeout_seen", 3);

    // 4: 0x12 request while busy is dropped, then 0xF4
    exp_q.push_back('{ack_err: 1'b0, timeout: 1'b0});
    send(8'hED);
    fork
      dev_frame(1'b1, smp);
      begin
        int n = 0;
        while (dev_nclk < 3 && n < 5000) begin
          @(negedge clk);
          n++;
        end
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        repeat (50) @(negedge clk);
        check("t4_busy_ready", tx_ready, 0);
        tx_valid = 1'b0;
      end
    join
    check("t4_bits", smp, frame_bits(8'hED));
    wait_event("t4_done_seen", 4);
    exp_q.push_back('{ack_err: 1'b0, timeout: 1'b0});
    send(8'hF4);
    dev_frame(1'b1, smp);
    check("t4_f4_bits", smp, frame_bits(8'hF4));
    wait_event("t4_f4_done_seen", 5);

    // 5: reset at data bit 4 aborts silently
    send(8'hED);
    fork
      dev_frame(1'b1, smp);
      begin
        int n = 0;
        while (dev_nclk < 5 && n < 5000) begin
          @(negedge clk);
          n++;
        end
        check("t5_reach_bit4", n < 5000, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_oe", {kclk_oe, kdata_oe}, 0);
        check("t5_ready", tx_ready, 1);
        check("t5_pulses", {done, ack_err, timeout}, 0);
      end
    join
    repeat (200) @(negedge clk);
    check("t5_no_events", ev_cnt, 5);
    exp_q.push_back('{ack_err: 1'b0, timeout: 1'b0});
    send(8'hED);
    dev_frame(1'b1, smp);
    check("t5_clean_bits", smp, frame_bits(8'hED));
    wait_event("t5_done_seen", 6);

    // 6: NACK then ACK
`ifdef PS2_TX_RESEND_EN
    exp_q.push_back('{ack_err: 1'b0, timeout: 1'b0});
    send(8'h3C);
    dev_frame(1'b0, smp);
    check("t6_bits_first", smp, frame_bits(8'h3C));
    dev_frame(1'b1, smp);
    check("t6_bits_retry", smp, frame_bits(8'h3C));
`else
    exp_q.push_back('{ack_err: 1'b1, timeout: 1'b0});
    send(8'h3C);
    dev_frame(1'b0, smp);
    check("t6_bits", smp, frame_bits(8'h3C));
`endif
    wait_event("t6_done_seen", 7);
    repeat (200) @(negedge clk);
    check("final_events", ev_cnt, 7);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
